handshake_master: RTL and testbench
===================================

# handshake_master

Requester side of the request/ack/valid handshake: buffers 3-bit payloads from a local producer in a small FIFO and delivers each one to the downstream slave controller. Each transfer raises `request`, waits for the slave's `ack`, presents the word with a one-cycle `valid`, then waits for the slave's data `ack`. Sits directly upstream of the slave controller and drives its `request`, `valid` and `data_in` inputs.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: cycles without progress before a transfer is aborted (only with the timeout feature); ≥2.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: **reset is asynchronous and active-high**; single clock domain.
- `wr_en` in 1: push `wr_data` when `full`=0.
- `wr_data` in 3: payload to enqueue.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `ack` in 1: from slave, request ack and data ack.
- `notice` in 1: from slave, high while slave is preparing ack.
- `request` out 1: registered request to slave.
- `valid` out 1: registered one-cycle data strobe.
- `data` out 3: registered payload, stable while `valid`=1.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse per completed transfer.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
- FIFO: circular buffer with `log2(DEPTH)`-bit pointers that wrap and a `log2(DEPTH)+1`-bit count. Write when `wr_en && !full`. Pop only on transfer completion. A write while `full` is dropped, even if a pop happens in the same cycle. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states:
  - IDLE: if `!empty`, go to REQ and set `request`<=1.
  - REQ: hold `request`=1. On `ack`=1, set `request`<=0, `valid`<=1, `data`<=head, and go to SEND.
  - SEND: set `valid`<=0 and go to DACK. This always takes exactly one cycle.
  - DACK: on `ack`=1, pop the head, pulse `done`, and go to IDLE.
- `data` holds its last value outside SEND.
- Timeout counter: cleared on entry to REQ or DACK and on any cycle with `notice`=1. Increments otherwise while in REQ or DACK. At `TIMEOUT`-1:
  - set `request`<=0 and `valid`<=0;
  - set `err`<=1;
  - go to IDLE without popping, so the entry is retried.
- `err_clr` clears `err`. If `err_clr` and a timeout occur in the same cycle, set wins.

## Timing
- Reset values: `request`=0, `valid`=0, `data`=0, `done`=0, `err`=0, `busy`=0, `empty`=1, `full`=0; pointers, count and timeout counter = 0; state IDLE.
- Reset asserted mid-transfer drops `request` and `valid` immediately and discards the FIFO contents.
- Write-to-request latency, with the FIFO empty and in IDLE: `wr_en` at edge N → `empty`=0 after N → `request`=1 after N+1.
- `request` falls and `valid` rises on the same edge, the one after which the first `ack`=1 is sampled. `valid` is high for exactly one cycle.
- The slave answers `valid` with `ack`=1 in the following cycle. `done` pulses the cycle after that `ack` is sampled, and `empty` or the count updates on the same edge as `done`.
- Back-to-back: after `done`, IDLE re-raises `request` on the next edge if the FIFO is non-empty. Minimum gap is 1 cycle with `request`=0.
- An `ack` sampled in IDLE or SEND is ignored.

## Configuration
- `HS_MASTER_TIMEOUT_EN`:
  - Defined: the timeout counter and the `err` logic described above are built.
  - Undefined: no counter; REQ and DACK wait indefinitely; `err` is tied 0; `err_clr` and `notice` are unused.

## Test plan
- Single transfer: push 3'b101 with the slave ack delay at 4 cycles → `request` high until ack; one `valid` cycle with `data`=3'b101; `done` pulses once; `empty`=1.
- Fill and drain: push 5,1,6,2 back-to-back (`DEPTH`=4) and then a fifth push of 7 → `full`=1 and 7 dropped; the slave receives 5,1,6,2 in order; four `done` pulses.
- Wrap-around: push and drain 10 words one at a time → every value is delivered in order; pointers wrap without loss.
- Timeout (macro on, `TIMEOUT`=8): `ack` and `notice` held 0 → `request` drops after 8 cycles in REQ, `err`=1, entry kept. Then enable ack → the same word is delivered. Then `err_clr` → `err`=0.
- `notice` extends the wait: `notice`=1 for 20 cycles, then `ack` → no timeout and `err`=0.
- Reset mid-transfer: assert `rst` while in SEND with 2 entries queued → `valid`, `request` and `done` are 0 immediately; `empty`=1 after release; no further `request`.

Source files
------------

// File: rtl/handshake_master.sv
// Requester side of the request/ack/valid handshake: a small FIFO feeds words to a slave.
// Optional timeout/err logic is built when HS_MASTER_TIMEOUT_EN is defined.
module handshake_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_data,
  output logic       full,
  output logic       empty,
  input  logic       ack,
  input  logic       notice,
  output logic       request,
  output logic       valid,
  output logic [2:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, SEND, DACK} state_t;

  state_t        state, state_n;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, abort, timeout_hit;
  logic          request_n, valid_n, done_n;
  logic [2:0]    data_n;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      request <= 1'b0;
      valid   <= 1'b0;
      data    <= 3'b000;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      request <= request_n;
      valid   <= valid_n;
      data    <= data_n;
      done    <= done_n;
    end
  end

  // An ack always counts as progress, so it wins over a timeout in the same cycle.
  always_comb begin
    state_n   = state;
    request_n = request;
    valid_n   = valid;
    data_n    = data;
    done_n    = 1'b0;
    pop       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n   = REQ;
          request_n = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          state_n   = SEND;
          request_n = 1'b0;
          valid_n   = 1'b1;
          data_n    = mem[rptr];
        end else if (timeout_hit) begin
          abort     = 1'b1;
          request_n = 1'b0;
          valid_n   = 1'b0;
          state_n   = IDLE;
        end
      end
      SEND: begin
        valid_n = 1'b0;
        state_n = DACK;
      end
      DACK: begin
        if (ack) begin
          pop     = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          request_n = 1'b0;
          valid_n   = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef HS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tcnt, tcnt_n;
  logic          waiting;

  assign waiting = (state == REQ) || (state == DACK);

  // IDLE and SEND always clear the counter, so every REQ/DACK entry starts from zero.
  always_comb begin
    tcnt_n      = tcnt;
    timeout_hit = 1'b0;
    if (!waiting || notice) begin
      tcnt_n = '0;
    end else if (tcnt == TW'(TIMEOUT - 1)) begin
      timeout_hit = 1'b1;
      tcnt_n      = '0;
    end else begin
      tcnt_n = tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      if (abort)        err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
`else
  logic unused_timeout_inputs;

  assign timeout_hit           = 1'b0;
  assign err                   = 1'b0;
  assign unused_timeout_inputs = ^{notice, err_clr, abort};
`endif

endmodule

// File: tb/tb_handshake_master.sv
// Self-checking bench for handshake_master: randomized words and ack delays checked
// against a queue model of the FIFO and the handshake timing rules.
module tb_handshake_master;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_data;
  logic       full, empty;
  logic       ack, notice;
  logic       request, valid;
  logic [2:0] data;
  logic       busy, done, err, err_clr;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model_q[$];

  handshake_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .ack     (ack),
    .notice  (notice),
    .request (request),
    .valid   (valid),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before the end of the run");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One push cycle; the model accepts the word only if it holds fewer than DEPTH words.
  task automatic applyStimulus(input logic [2:0] value);
    @(negedge clk);
    checkOutput("full_before_push", full, model_q.size() == DEPTH);
    wr_en   = 1'b1;
    wr_data = value;
    if (model_q.size() < DEPTH) model_q.push_back(value);
  endtask

  task automatic endPush();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic waitRequest();
    int n = 0;
    while (request !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_request", request, 1'b1);
  endtask

  // Plays the slave for one transfer: request ack after ack_delay cycles, data ack right after valid.
  task automatic serveTransfer(input int ack_delay);
    logic [2:0] expect_word;
    waitRequest();
    expect_word = (model_q.size() > 0) ? model_q[0] : 3'b000;
    for (int i = 0; i < ack_delay; i++) begin
      ack = 1'b0;
      @(negedge clk);
      checkOutput("request_held", request, 1'b1);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("request_fall", request, 1'b0);
    checkOutput("valid_rise", valid, 1'b1);
    checkOutput("data_word", data, expect_word);
    @(negedge clk);
    checkOutput("valid_one_cycle", valid, 1'b0);
    checkOutput("data_stable", data, expect_word);
    checkOutput("done_early", done, 1'b0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("empty_after_pop", empty, model_q.size() == 0);
    checkOutput("request_gap", request, 1'b0);
    @(negedge clk);
    checkOutput("done_single", done, 1'b0);
  endtask

  initial begin
    logic [2:0] fill_words [5];
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 3'b000;
    ack     = 1'b0;
    notice  = 1'b1;
    err_clr = 1'b0;

    @(negedge clk);
    checkOutput("rst_request", request, 1'b0);
    checkOutput("rst_valid", valid, 1'b0);
    checkOutput("rst_data", data, 3'b000);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single transfer");
    applyStimulus(3'b101);
    endPush();
    checkOutput("latency_empty", empty, 1'b0);
    checkOutput("latency_request_low", request, 1'b0);
    @(negedge clk);
    checkOutput("latency_request_high", request, 1'b1);
    checkOutput("busy_in_req", busy, 1'b1);
    serveTransfer(4);
    checkOutput("single_empty", empty, 1'b1);

    $display("[TB] fill and drain");
    fill_words = '{3'd5, 3'd1, 3'd6, 3'd2, 3'd7};
    for (int i = 0; i < 5; i++) applyStimulus(fill_words[i]);
    endPush();
    checkOutput("fill_full", full, 1'b1);
    checkOutput("fill_model_size", 4'(model_q.size()), 4'd4);
    for (int i = 0; i < 4; i++) serveTransfer(int'($urandom_range(0, 5)));
    checkOutput("drain_empty", empty, 1'b1);

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'($urandom_range(0, 7)));
      endPush();
      serveTransfer(int'($urandom_range(0, 5)));
      checkOutput("wrap_empty", empty, 1'b1);
    end

`ifdef HS_MASTER_TIMEOUT_EN
    $display("[TB] timeout");
    notice = 1'b0;
    applyStimulus(3'b011);
    endPush();
    waitRequest();
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput("timeout_request_held", request, 1'b1);
      checkOutput("timeout_err_low", err, 1'b0);
      @(negedge clk);
    end
    checkOutput("timeout_request_drop", request, 1'b0);
    checkOutput("timeout_err_set", err, 1'b1);
    checkOutput("timeout_entry_kept", empty, 1'b0);
    checkOutput("timeout_idle", busy, 1'b0);
    serveTransfer(1);
    checkOutput("timeout_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_cleared", err, 1'b0);

    $display("[TB] notice extends wait");
    notice = 1'b1;
    applyStimulus(3'b110);
    endPush();
    serveTransfer(20);
    checkOutput("notice_no_err", err, 1'b0);
`endif

    $display("[TB] reset mid-transfer");
    for (int i = 0; i < 3; i++) applyStimulus(3'($urandom_range(0, 7)));
    endPush();
    waitRequest();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("midrst_in_send", valid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", valid, 1'b0);
    checkOutput("midrst_request", request, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    checkOutput("midrst_empty", empty, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_request", request, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
